// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types: shared types for the LC-3b instruction-fetch stage.
//   if_id_t       : IF_ID pipeline register {valid, pc_out, intr}
//   fetch_state_t : fetch FSM states {FETCH, HOLD, SQUASH}
//   pc_op_t       : PC register update selector
//   if_op_t       : IF_ID register update selector
//   PCMUX_*       : redirect source encodings carried on pcmux_sel
//   pc_plus2()    : sequential PC increment (wraps mod 2^16)
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc_out;
        logic [15:0] intr;
    } if_id_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_KEEP    = 2'd0,
        PC_INC     = 2'd1,
        PC_TARGET  = 2'd2,
        PC_PENDING = 2'd3
    } pc_op_t;

    typedef enum logic [1:0] {
        IF_KEEP       = 2'd0,
        IF_LOAD_FETCH = 2'd1,
        IF_LOAD_HOLD  = 2'd2,
        IF_BUBBLE     = 2'd3
    } if_op_t;

    // Redirect sources: branch miss falls through to wb_pc, JMP/JSR/TRAP use new_pc.
    localparam logic [1:0] PCMUX_WB_PC  = 2'b00;
    localparam logic [1:0] PCMUX_JMP    = 2'b01;
    localparam logic [1:0] PCMUX_TRAP   = 2'b10;
    localparam logic [1:0] PCMUX_BR_MIS = 2'b11;

    // All-zero IF_ID: intr 16'h0000 decodes as BR with nzp=000, i.e. a NOP.
    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc_out: 16'h0000, intr: 16'h0000};

    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_stage_redirect_mux.sv
// -----------------------------------------------------------------------------
// fetch_redirect_mux: selects the redirect target from the writeback interface
// and clears its LSB so the PC stays word aligned.
//   pcmux_sel in 2  : redirect source
//   new_pc    in 16 : JMP/JSR/TRAP target (sel 01/10)
//   wb_pc     in 16 : fall-through PC on branch miss (sel 00/11)
//   target    out 16: aligned redirect target
// -----------------------------------------------------------------------------
module fetch_redirect_mux
    import lc3b_types::*;
(
    input  logic [1:0]  pcmux_sel,
    input  logic [15:0] new_pc,
    input  logic [15:0] wb_pc,
    output logic [15:0] target
);

    logic [15:0] raw_target_s;

    // Source select; unknown encodings fall back to the writeback PC.
    always_comb begin
        raw_target_s = wb_pc;
        case (pcmux_sel)
            PCMUX_JMP:    raw_target_s = new_pc;
            PCMUX_TRAP:   raw_target_s = new_pc;
            PCMUX_WB_PC:  raw_target_s = wb_pc;
            PCMUX_BR_MIS: raw_target_s = wb_pc;
            default:      raw_target_s = wb_pc;
        endcase
    end

    assign target = {raw_target_s[15:1], 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: LC-3b instruction fetch. Owns the PC, drives the I-cache read
// handshake, loads IF_ID, and applies writeback redirects (flush).
//   clk, rst                  : clock, async active-high reset
//   flush, pcmux_sel, new_pc, wb_pc : redirect interface from writeback
//   stall                     : downstream hazard; holds IF_ID
//   icache_rdata/resp         : I-cache read data and 1-cycle completion pulse
//   icache_read/address       : read request (held until resp) and fetch address
//   if_id                     : IF_ID pipeline register {valid, pc+2, intr}
// Optional (FETCH_SQUASH_COUNT_EN): squash_count_out / squash_count_clr, a
// saturating count of discarded fetches.
// -----------------------------------------------------------------------------
module fetch_stage
    import lc3b_types::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  pcmux_sel,
    input  logic [15:0] new_pc,
    input  logic [15:0] wb_pc,
    input  logic        stall,
    input  logic [15:0] icache_rdata,
    input  logic        icache_resp,
    output logic        icache_read,
    output logic [15:0] icache_address,
`ifdef FETCH_SQUASH_COUNT_EN
    output logic [15:0] squash_count_out,
    input  logic        squash_count_clr,
`endif
    output if_id_t      if_id
);

    fetch_state_t state_r, state_next_s;
    pc_op_t       pc_op_s;
    if_op_t       if_op_s;
    logic         hold_load_s;
    logic         pending_load_s;
    logic         discard_s;
    logic [15:0]  target_s;
    logic [15:0]  pc_r;
    logic [15:0]  pending_pc_r;
    logic [15:0]  hold_pc_r;
    logic [15:0]  hold_intr_r;
    if_id_t       if_id_r;

    fetch_redirect_mux u_redirect_mux (
        .pcmux_sel (pcmux_sel),
        .new_pc    (new_pc),
        .wb_pc     (wb_pc),
        .target    (target_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode. Flush always wins over stall.
    always_comb begin
        state_next_s   = state_r;
        pc_op_s        = PC_KEEP;
        if_op_s        = IF_KEEP;
        hold_load_s    = 1'b0;
        pending_load_s = 1'b0;
        discard_s      = 1'b0;
        case (state_r)
            FETCH: begin
                if (flush) begin
                    if_op_s = IF_BUBBLE;
                    if (icache_resp) begin
                        pc_op_s   = PC_TARGET;
                        discard_s = 1'b1;
                    end else begin
                        // Read cannot be aborted: park the target until resp.
                        pending_load_s = 1'b1;
                        state_next_s   = SQUASH;
                    end
                end else if (icache_resp) begin
                    pc_op_s = PC_INC;
                    if (stall) begin
                        hold_load_s  = 1'b1;
                        state_next_s = HOLD;
                    end else begin
                        if_op_s = IF_LOAD_FETCH;
                    end
                end else if (!stall) begin
                    if_op_s = IF_BUBBLE;
                end else begin
                    if_op_s = IF_KEEP;
                end
            end
            HOLD: begin
                if (flush) begin
                    if_op_s      = IF_BUBBLE;
                    pc_op_s      = PC_TARGET;
                    discard_s    = 1'b1;
                    state_next_s = FETCH;
                end else if (!stall) begin
                    if_op_s      = IF_LOAD_HOLD;
                    state_next_s = FETCH;
                end else begin
                    if_op_s = IF_KEEP;
                end
            end
            SQUASH: begin
                if (flush) begin
                    if_op_s = IF_BUBBLE;
                    if (icache_resp) begin
                        pc_op_s      = PC_TARGET;
                        discard_s    = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        // Newest redirect wins.
                        pending_load_s = 1'b1;
                    end
                end else begin
                    if_op_s = stall ? IF_KEEP : IF_BUBBLE;
                    if (icache_resp) begin
                        pc_op_s      = PC_PENDING;
                        discard_s    = 1'b1;
                        state_next_s = FETCH;
                    end else begin
                        pc_op_s = PC_KEEP;
                    end
                end
            end
            default: begin
                state_next_s = FETCH;
                if_op_s      = IF_BUBBLE;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            case (pc_op_s)
                PC_INC:     pc_r <= pc_plus2(pc_r);
                PC_TARGET:  pc_r <= target_s;
                PC_PENDING: pc_r <= pending_pc_r;
                PC_KEEP:    pc_r <= pc_r;
                default:    pc_r <= pc_r;
            endcase
        end
    end

    // Redirect target parked while a squashed read drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_pc_r <= RESET_PC;
        end else if (pending_load_s) begin
            pending_pc_r <= target_s;
        end else begin
            pending_pc_r <= pending_pc_r;
        end
    end

    // Instruction buffered when a fetch completes during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pc_r   <= 16'h0000;
            hold_intr_r <= 16'h0000;
        end else if (hold_load_s) begin
            hold_pc_r   <= pc_plus2(pc_r);
            hold_intr_r <= icache_rdata;
        end else begin
            hold_pc_r   <= hold_pc_r;
            hold_intr_r <= hold_intr_r;
        end
    end

    // IF_ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_r <= IF_ID_BUBBLE;
        end else begin
            case (if_op_s)
                IF_LOAD_FETCH: if_id_r <= '{valid: 1'b1, pc_out: pc_plus2(pc_r), intr: icache_rdata};
                IF_LOAD_HOLD:  if_id_r <= '{valid: 1'b1, pc_out: hold_pc_r, intr: hold_intr_r};
                IF_BUBBLE:     if_id_r <= IF_ID_BUBBLE;
                IF_KEEP:       if_id_r <= if_id_r;
                default:       if_id_r <= IF_ID_BUBBLE;
            endcase
        end
    end

`ifdef FETCH_SQUASH_COUNT_EN
    logic [15:0] squash_count_r;

    // Saturating count of discarded fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_count_r <= 16'h0000;
        end else if (squash_count_clr) begin
            squash_count_r <= 16'h0000;
        end else if (discard_s && (squash_count_r != 16'hFFFF)) begin
            squash_count_r <= squash_count_r + 16'd1;
        end else begin
            squash_count_r <= squash_count_r;
        end
    end

    assign squash_count_out = squash_count_r;
`endif

    // Read is gated by rst so the request is low throughout reset.
    assign icache_read    = !rst && ((state_r == FETCH) || (state_r == SQUASH));
    assign icache_address = pc_r;
    assign if_id          = if_id_r;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  pcmux_sel;
    logic [15:0] new_pc;
    logic [15:0] wb_pc;
    logic        stall;
    logic [15:0] icache_rdata;
    logic        icache_resp;
    logic        icache_read;
    logic [15:0] icache_address;
    if_id_t      if_id;
`ifdef FETCH_SQUASH_COUNT_EN
    logic [15:0] squash_count_out;
    logic        squash_count_clr;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .pcmux_sel      (pcmux_sel),
        .new_pc         (new_pc),
        .wb_pc          (wb_pc),
        .stall          (stall),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .icache_read    (icache_read),
        .icache_address (icache_address),
`ifdef FETCH_SQUASH_COUNT_EN
        .squash_count_out (squash_count_out),
        .squash_count_clr (squash_count_clr),
`endif
        .if_id          (if_id)
    );

    typedef struct {
        logic        flush;
        logic [1:0]  sel;
        logic [15:0] npc;
        logic [15:0] wpc;
        logic        stall;
        logic        resp;
        logic [15:0] rdata;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_intr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic f, input logic [1:0] s, input logic [15:0] np,
                                input logic [15:0] wp, input logic st, input logic rs,
                                input logic [15:0] rd, input logic er, input logic [15:0] ea,
                                input logic ev, input logic [15:0] epc, input logic [15:0] ei,
                                input logic [15:0] ec);
        vec_t v;
        v.flush = f;  v.sel = s;  v.npc = np; v.wpc = wp; v.stall = st; v.resp = rs;
        v.rdata = rd; v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = epc;
        v.e_intr = ei; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic f, input logic [1:0] s, input logic [15:0] np,
                         input logic [15:0] wp, input logic st, input logic rs,
                         input logic [15:0] rd);
        flush = f; pcmux_sel = s; new_pc = np; wb_pc = wp;
        stall = st; icache_resp = rs; icache_rdata = rd;
    endtask

    initial begin
        // Per cycle: inputs, then outputs expected during that cycle (before its edge).
        //            flush sel npc      wpc      stl rsp rdata    read addr     v  pc_out   intr     cnt
        tbl[0]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[1]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'hA000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[2]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0002, 16'hA000, 16'd0);
        tbl[3]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'hA002, 1, 16'h0002, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[4]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0004, 16'hA002, 16'd0);
        tbl[5]  = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'hA004, 1, 16'h0004, 0, 16'h0000, 16'h0000, 16'd0);
        // stall: hold valid IF_ID, then a resp during stall goes to HOLD
        tbl[6]  = mk(0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0006, 16'hA004, 16'd0);
        tbl[7]  = mk(0, 2'd0, 16'h0000, 16'h0000, 1, 1, 16'hA006, 1, 16'h0006, 1, 16'h0006, 16'hA004, 16'd0);
        tbl[8]  = mk(0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'hA004, 16'd0);
        tbl[9]  = mk(0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'hA004, 16'd0);
        tbl[10] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 16'hA004, 16'd0);
        tbl[11] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 1, 16'h0008, 16'hA006, 16'd0);
        // branch-miss flush while the read at 0x0008 is outstanding
        tbl[12] = mk(1, 2'd3, 16'h5554, 16'h3002, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[13] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[14] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'hBAD0, 1, 16'h0008, 0, 16'h0000, 16'h0000, 16'd0);
        tbl[15] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 1, 16'h3002, 0, 16'h0000, 16'h0000, 16'd1);
        // JMP flush coincident with resp and stall; odd target gets aligned
        tbl[16] = mk(1, 2'd1, 16'h4001, 16'h7776, 1, 1, 16'hBAD1, 1, 16'h3004, 1, 16'h3004, 16'h1234, 16'd1);
        tbl[17] = mk(0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000, 16'd2);
        // two flushes in SQUASH, newest wins
        tbl[18] = mk(1, 2'd2, 16'h1000, 16'h6666, 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000, 16'd2);
        tbl[19] = mk(1, 2'd0, 16'h5555, 16'h2000, 0, 0, 16'h0000, 1, 16'h4000, 0, 16'h0000, 16'h0000, 16'd2);
        tbl[20] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'hBAD2, 1, 16'h4000, 0, 16'h0000, 16'h0000, 16'd2);
        tbl[21] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'h2200, 1, 16'h2000, 0, 16'h0000, 16'h0000, 16'd3);
        // redirect to 0xFFFE, then wrap
        tbl[22] = mk(1, 2'd1, 16'hFFFF, 16'h1110, 0, 1, 16'hBAD3, 1, 16'h2002, 1, 16'h2002, 16'h2200, 16'd3);
        tbl[23] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'h7E7E, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'd4);
        tbl[24] = mk(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0000, 16'h7E7E, 16'd4);

        rst = 1'b1;
        drive(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
`ifdef FETCH_SQUASH_COUNT_EN
        squash_count_clr = 1'b0;
`endif
        #2;
        chk("reset_read",  {15'd0, icache_read}, 16'd0);
        chk("reset_addr",  icache_address, 16'h0000);
        chk("reset_valid", {15'd0, if_id.valid}, 16'd0);
        chk("reset_intr",  if_id.intr, 16'h0000);
        chk("reset_pcout", if_id.pc_out, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].flush, tbl[i].sel, tbl[i].npc, tbl[i].wpc,
                  tbl[i].stall, tbl[i].resp, tbl[i].rdata);
            #1;
            chk($sformatf("v%0d_read", i), {15'd0, icache_read}, {15'd0, tbl[i].e_read});
            if (tbl[i].e_read) chk($sformatf("v%0d_addr", i), icache_address, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {15'd0, if_id.valid}, {15'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_pcout", i), if_id.pc_out, tbl[i].e_pc);
            chk($sformatf("v%0d_intr", i), if_id.intr, tbl[i].e_intr);
`ifdef FETCH_SQUASH_COUNT_EN
            chk($sformatf("v%0d_cnt", i), squash_count_out, tbl[i].e_cnt);
`endif
        end

        // Async reset while a squashed read is outstanding.
        @(negedge clk);
        drive(1, 2'd1, 16'h0800, 16'h0000, 0, 0, 16'h0000);
        @(negedge clk);
        drive(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        #1;
        chk("sq_read", {15'd0, icache_read}, 16'd1);
        chk("sq_addr", icache_address, 16'h0000);
        rst = 1'b1;
        #1;
        chk("arst_read",  {15'd0, icache_read}, 16'd0);
        chk("arst_valid", {15'd0, if_id.valid}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_post_read", {15'd0, icache_read}, 16'd1);
        chk("arst_post_addr", icache_address, 16'h0000);

        // Fetch, stall into HOLD, then flush drops the buffered instruction.
        drive(0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'h4444);
        @(posedge clk); #1;
        chk("hs_valid", {15'd0, if_id.valid}, 16'd1);
        chk("hs_pcout", if_id.pc_out, 16'h0002);
        chk("hs_intr",  if_id.intr, 16'h4444);
        @(negedge clk);
        drive(0, 2'd0, 16'h0000, 16'h0000, 1, 1, 16'h5555);
        @(posedge clk); #1;
        chk("hs_hold_read", {15'd0, icache_read}, 16'd0);
        @(negedge clk);
        drive(1, 2'd1, 16'h0A01, 16'h0000, 1, 0, 16'h0000);
        @(posedge clk); #1;
        chk("hd_valid", {15'd0, if_id.valid}, 16'd0);
        chk("hd_read",  {15'd0, icache_read}, 16'd1);
        chk("hd_addr",  icache_address, 16'h0A00);
`ifdef FETCH_SQUASH_COUNT_EN
        chk("hd_cnt", squash_count_out, 16'd1);
        @(negedge clk);
        drive(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        squash_count_clr = 1'b1;
        @(posedge clk); #1;
        squash_count_clr = 1'b0;
        chk("clr_cnt", squash_count_out, 16'd0);
`endif
        @(negedge clk);
        drive(0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(posedge clk); #1;
        chk("hd_no_leak", {15'd0, if_id.valid}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
